// File: rtl/captura_pkg.sv
// rtl/captura_pkg.sv - capture FSM encoding, output mode codes and RGB565 to 8-bit conversion
package captura_pkg;

  typedef enum logic [1:0] {
    ST_WAIT_VS_HIGH = 2'd0,
    ST_WAIT_VS_LOW  = 2'd1,
    ST_ROW_WAIT     = 2'd2,
    ST_ROW_CAPTURE  = 2'd3
  } state_e;

  localparam logic [1:0] MODE_RGB332 = 2'd0;
  localparam logic [1:0] MODE_GRAY8  = 2'd1;
  localparam logic [1:0] MODE_RAW_HI = 2'd2;

  // Gray weights R and B at 8x against the 6-bit G so a white pixel saturates to 0xFF.
  function automatic logic [7:0] rgb565_to_8(input logic [1:0] mode, input logic [15:0] pix);
    logic [4:0] r;
    logic [5:0] g;
    logic [4:0] b;
    logic [9:0] sum;
    logic [9:0] half;
    logic [7:0] res;
    r    = pix[15:11];
    g    = pix[10:5];
    b    = pix[4:0];
    sum  = {2'b00, r, 3'b000} + {4'b0000, g} + {2'b00, b, 3'b000};
    half = sum >> 1;
    case (mode)
      MODE_GRAY8:  res = (half > 10'd255) ? 8'hFF : half[7:0];
      MODE_RAW_HI: res = pix[15:8];
      default:     res = {r[4:2], g[5:3], b[4:3]};
    endcase
    return res;
  endfunction

endpackage

// File: rtl/pixel_format_conv.sv
// rtl/pixel_format_conv.sv - combinational RGB565 pixel to 8-bit output format
module pixel_format_conv
  import captura_pkg::*;
(
  input  logic [1:0]  mode_i,
  input  logic [15:0] pixel_i,
  output logic [7:0]  data_o
);

  assign data_o = rgb565_to_8(mode_i, pixel_i);

endmodule

// File: rtl/captura_datos_param.sv
// rtl/captura_datos_param.sv - camera frame capture with decimation into a dual-port RAM
module captura_datos_param
  import captura_pkg::*;
#(
  parameter int IMG_W    = 160,
  parameter int IMG_H    = 120,
  parameter int DEC_LOG2 = 2,
  parameter int ADDR_W   = 15
) (
  input  logic              pclk,
  input  logic              rst,
  input  logic              vsync,
  input  logic              href,
  input  logic [7:0]        data,
  input  logic              enable,
  input  logic [1:0]        mode,
  output logic [ADDR_W-1:0] DP_RAM_addr_out,
  output logic [7:0]        DP_RAM_data_out,
  output logic              DP_RAM_regW,
  output logic              frame_done,
  output logic              overflow
);

  localparam int CNT_W = 16;
  localparam logic [CNT_W-1:0] DEC_MASK = CNT_W'((1 << DEC_LOG2) - 1);
  localparam logic [CNT_W-1:0] IMG_W_C  = CNT_W'(IMG_W);
  localparam logic [CNT_W-1:0] IMG_H_C  = CNT_W'(IMG_H);
  localparam logic [ADDR_W-1:0] ROW_STEP = ADDR_W'(IMG_W);

  if (IMG_W * IMG_H > (2 ** ADDR_W)) begin : g_size_check
    $error("captura_datos_param: IMG_W*IMG_H does not fit in ADDR_W address bits");
  end

  state_e            state_q, state_d;
  logic [1:0]        mode_q, mode_d;
  logic              phase_q, phase_d;
  logic [7:0]        hi_q, hi_d;
  logic [CNT_W-1:0]  src_col_q, src_col_d;
  logic [CNT_W-1:0]  src_row_q, src_row_d;
  logic [ADDR_W-1:0] row_base_q, row_base_d;
  logic              wrote_any_q, wrote_any_d;
  logic [ADDR_W-1:0] addr_q, addr_d;
  logic [7:0]        wdata_q, wdata_d;
  logic              regw_q, regw_d;
  logic              done_q, done_d;
  logic              ovf_q, ovf_d;

  logic [7:0]        conv_data;
  logic [CNT_W-1:0]  out_col;
  logic [CNT_W-1:0]  out_row;
  logic              row_kept;
  logic              col_kept;

  pixel_format_conv u_conv (
    .mode_i  (mode_q),
    .pixel_i ({hi_q, data}),
    .data_o  (conv_data)
  );

  assign out_col  = src_col_q >> DEC_LOG2;
  assign out_row  = src_row_q >> DEC_LOG2;
  assign row_kept = (src_row_q & DEC_MASK) == '0;
  assign col_kept = (src_col_q & DEC_MASK) == '0;

  always_comb begin
    state_d     = state_q;
    mode_d      = mode_q;
    phase_d     = phase_q;
    hi_d        = hi_q;
    src_col_d   = src_col_q;
    src_row_d   = src_row_q;
    row_base_d  = row_base_q;
    wrote_any_d = wrote_any_q;
    addr_d      = addr_q;
    wdata_d     = wdata_q;
    ovf_d       = ovf_q;
    regw_d      = 1'b0;
    done_d      = 1'b0;

    case (state_q)
      ST_WAIT_VS_HIGH: begin
        if (vsync) state_d = ST_WAIT_VS_LOW;
      end

      ST_WAIT_VS_LOW: begin
        if (!vsync && enable) begin
          state_d     = ST_ROW_WAIT;
          mode_d      = mode;
          phase_d     = 1'b0;
          src_col_d   = '0;
          src_row_d   = '0;
          row_base_d  = '0;
          addr_d      = '0;
          ovf_d       = 1'b0;
          wrote_any_d = 1'b0;
        end
      end

      ST_ROW_WAIT: begin
        if (vsync) begin
          state_d = ST_WAIT_VS_LOW;
          done_d  = wrote_any_q;
        end else if (href) begin
          state_d   = ST_ROW_CAPTURE;
          hi_d      = data;
          phase_d   = 1'b1;
          src_col_d = '0;
        end
      end

      ST_ROW_CAPTURE: begin
        if (vsync) begin
          state_d = ST_WAIT_VS_LOW;
          done_d  = wrote_any_q;
        end else if (!href) begin
          // A kept source row owns one output row of RAM, whether or not it was complete.
          state_d   = ST_ROW_WAIT;
          phase_d   = 1'b0;
          src_row_d = src_row_q + CNT_W'(1);
          if (row_kept) row_base_d = row_base_q + ROW_STEP;
        end else if (!phase_q) begin
          hi_d    = data;
          phase_d = 1'b1;
        end else begin
          phase_d   = 1'b0;
          src_col_d = src_col_q + CNT_W'(1);
          if (row_kept && col_kept) begin
            if (out_row >= IMG_H_C) begin
              ovf_d = 1'b1;
            end else if (out_col < IMG_W_C) begin
              regw_d      = 1'b1;
              addr_d      = row_base_q + ADDR_W'(out_col);
              wdata_d     = conv_data;
              wrote_any_d = 1'b1;
            end
          end
        end
      end

      default: state_d = ST_WAIT_VS_HIGH;
    endcase
  end

  always_ff @(posedge pclk) begin
    if (rst) begin
      state_q     <= ST_WAIT_VS_HIGH;
      mode_q      <= MODE_RGB332;
      phase_q     <= 1'b0;
      hi_q        <= '0;
      src_col_q   <= '0;
      src_row_q   <= '0;
      row_base_q  <= '0;
      wrote_any_q <= 1'b0;
      addr_q      <= '0;
      wdata_q     <= '0;
      regw_q      <= 1'b0;
      done_q      <= 1'b0;
      ovf_q       <= 1'b0;
    end else begin
      state_q     <= state_d;
      mode_q      <= mode_d;
      phase_q     <= phase_d;
      hi_q        <= hi_d;
      src_col_q   <= src_col_d;
      src_row_q   <= src_row_d;
      row_base_q  <= row_base_d;
      wrote_any_q <= wrote_any_d;
      addr_q      <= addr_d;
      wdata_q     <= wdata_d;
      regw_q      <= regw_d;
      done_q      <= done_d;
      ovf_q       <= ovf_d;
    end
  end

  assign DP_RAM_addr_out = addr_q;
  assign DP_RAM_data_out = wdata_q;
  assign DP_RAM_regW     = regw_q;
  assign frame_done      = done_q;
  assign overflow        = ovf_q;

endmodule

// File: tb/tb_captura_datos_param.sv
// tb/tb_captura_datos_param.sv - self-checking bench for captura_datos_param in three configurations
module tb_captura_datos_param;

  typedef struct { int addr; int data; } wr_t;
  typedef struct { int md; int pix; int exp; } vec_t;

  logic       pclk = 1'b0;
  logic       rst, vsync, href, enable;
  logic [7:0] data;
  logic [1:0] mode;

  logic [14:0] a0; logic [7:0] d0; logic w0, f0, o0;
  logic [2:0]  a1; logic [7:0] d1; logic w1, f1, o1;
  logic [5:0]  a2; logic [7:0] d2; logic w2, f2, o2;

  always #5 pclk = ~pclk;

  captura_datos_param dut0 (
    .pclk(pclk), .rst(rst), .vsync(vsync), .href(href), .data(data), .enable(enable), .mode(mode),
    .DP_RAM_addr_out(a0), .DP_RAM_data_out(d0), .DP_RAM_regW(w0), .frame_done(f0), .overflow(o0));
  captura_datos_param #(.IMG_W(4), .IMG_H(2), .DEC_LOG2(0), .ADDR_W(3)) dut1 (
    .pclk(pclk), .rst(rst), .vsync(vsync), .href(href), .data(data), .enable(enable), .mode(mode),
    .DP_RAM_addr_out(a1), .DP_RAM_data_out(d1), .DP_RAM_regW(w1), .frame_done(f1), .overflow(o1));
  captura_datos_param #(.IMG_W(8), .IMG_H(6), .DEC_LOG2(2), .ADDR_W(6)) dut2 (
    .pclk(pclk), .rst(rst), .vsync(vsync), .href(href), .data(data), .enable(enable), .mode(mode),
    .DP_RAM_addr_out(a2), .DP_RAM_data_out(d2), .DP_RAM_regW(w2), .frame_done(f2), .overflow(o2));

  int p_w [3] = '{160, 4, 8};
  int p_h [3] = '{120, 2, 6};
  int p_d [3] = '{2, 0, 2};

  int   n_checks = 0;
  int   n_fail   = 0;
  wr_t  got0[$], got1[$], got2[$];
  int   done0 = 0, done1 = 0, done2 = 0;
  int   gs [3];
  int   ds [3];
  int   last_ovf [3];
  int   fb[$];
  int   rl[$];
  wr_t  exp_q[$];
  int   exp_ovf;
  int   cur_mode;
  bit   cur_en;
  vec_t tbl [10];

  function automatic wr_t mk_wr(input int a, input int d);
    wr_t w;
    w.addr = a;
    w.data = d;
    return w;
  endfunction

  always @(negedge pclk) begin
    if (w0) got0.push_back(mk_wr(int'(a0), int'(d0)));
    if (w1) got1.push_back(mk_wr(int'(a1), int'(d1)));
    if (w2) got2.push_back(mk_wr(int'(a2), int'(d2)));
    if (f0) done0 <= done0 + 1;
    if (f1) done1 <= done1 + 1;
    if (f2) done2 <= done2 + 1;
  end

  function automatic int out_of(input int k, input int f);
    int v [5];
    if (k == 0)      v = '{int'(a0), int'(d0), int'(w0), int'(f0), int'(o0)};
    else if (k == 1) v = '{int'(a1), int'(d1), int'(w1), int'(f1), int'(o1)};
    else             v = '{int'(a2), int'(d2), int'(w2), int'(f2), int'(o2)};
    return v[f];
  endfunction

  function automatic int got_sz(input int k);
    return (k == 0) ? got0.size() : (k == 1) ? got1.size() : got2.size();
  endfunction

  function automatic wr_t got_at(input int k, input int i);
    return (k == 0) ? got0[i] : (k == 1) ? got1[i] : got2[i];
  endfunction

  function automatic int done_of(input int k);
    return (k == 0) ? done0 : (k == 1) ? done1 : done2;
  endfunction

  // Reference conversion straight from the channel arithmetic of each output format.
  function automatic int ref_conv(input int md, input int pix);
    int r, g, b, y;
    r = (pix >> 11) & 31;
    g = (pix >> 5) & 63;
    b = pix & 31;
    if (md == 1) begin
      y = (8 * r + g + 8 * b) / 2;
      return (y > 255) ? 255 : y;
    end
    if (md == 2) return pix >> 8;
    return ((r >> 2) << 5) | ((g >> 3) << 2) | (b >> 3);
  endfunction

  task automatic check(input string name, input int act, input int exp);
    n_checks++;
    if (act != exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
    end
  endtask

  task automatic tick(input int n);
    repeat (n) begin
      @(posedge pclk);
      #1;
    end
  endtask

  task automatic mark();
    for (int k = 0; k < 3; k++) begin
      gs[k] = got_sz(k);
      ds[k] = done_of(k);
    end
  endtask

  task automatic check_zero(input string tag);
    string fname [5] = '{"addr", "data", "regW", "frame_done", "overflow"};
    for (int k = 0; k < 3; k++)
      for (int f = 0; f < 5; f++)
        check($sformatf("%s dut%0d %s", tag, k, fname[f]), out_of(k, f), 0);
  endtask

  task automatic gen_frame(input int nrows, input int pmin, input int pmax);
    fb.delete();
    rl.delete();
    for (int r = 0; r < nrows; r++) begin
      int len;
      len = 2 * int'($urandom_range(pmax, pmin)) + (($urandom_range(0, 3) == 0) ? 1 : 0);
      rl.push_back(len);
      for (int b = 0; b < len; b++) fb.push_back(int'($urandom_range(0, 255)));
    end
  endtask

  // Frame model: keep every 2**DEC-th pixel of every 2**DEC-th row, place it row-major.
  task automatic model_run(input int k);
    int off, dv, npix, pix, orow, ocol;
    exp_q.delete();
    exp_ovf = 0;
    if (!cur_en) begin
      exp_ovf = last_ovf[k];
      return;
    end
    dv  = 1 << p_d[k];
    off = 0;
    for (int r = 0; r < rl.size(); r++) begin
      npix = rl[r] / 2;
      for (int c = 0; c < npix; c++) begin
        if ((r % dv) == 0 && (c % dv) == 0) begin
          orow = r / dv;
          ocol = c / dv;
          pix  = (fb[off + 2 * c] << 8) | fb[off + 2 * c + 1];
          if (orow >= p_h[k]) exp_ovf = 1;
          else if (ocol < p_w[k]) exp_q.push_back(mk_wr(orow * p_w[k] + ocol, ref_conv(cur_mode, pix)));
        end
      end
      off += rl[r];
    end
  endtask

  task automatic send_frame(input int md, input bit en, input bit abort_mid, input bit chg_mid);
    int off;
    mark();
    cur_mode = md;
    cur_en   = en;
    href     = 1'b0;
    vsync    = 1'b1;
    enable   = en;
    mode     = 2'(md);
    tick(3);
    vsync = 1'b0;
    tick(2);
    off = 0;
    for (int r = 0; r < rl.size(); r++) begin
      href = 1'b0;
      tick(2);
      for (int b = 0; b < rl[r]; b++) begin
        href = 1'b1;
        data = 8'(fb[off + b]);
        tick(1);
      end
      off += rl[r];
      if (!(abort_mid && r == rl.size() - 1)) href = 1'b0;
      if (chg_mid && r == 0) begin
        mode   = 2'($urandom_range(0, 3));
        enable = 1'b0;
      end
    end
    vsync = 1'b1;
    tick(1);
    href = 1'b0;
    tick(4);
  endtask

  task automatic check_frame(input string tag);
    int  n;
    wr_t w;
    for (int k = 0; k < 3; k++) begin
      model_run(k);
      n = got_sz(k) - gs[k];
      check($sformatf("%s dut%0d write count", tag, k), n, exp_q.size());
      for (int i = 0; i < n && i < exp_q.size(); i++) begin
        w = got_at(k, gs[k] + i);
        check($sformatf("%s dut%0d write%0d addr:data", tag, k, i),
              (w.addr << 8) | w.data, (exp_q[i].addr << 8) | exp_q[i].data);
      end
      check($sformatf("%s dut%0d overflow", tag, k), out_of(k, 4), exp_ovf);
      last_ovf[k] = exp_ovf;
      check($sformatf("%s dut%0d frame_done pulses", tag, k), done_of(k) - ds[k],
            (cur_en && exp_q.size() > 0) ? 1 : 0);
    end
  endtask

  initial begin
    #3000000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    wr_t w;
    tbl = '{'{1, 'hFFFF, 'hFF}, '{1, 'h07E0, 'h1F}, '{0, 'hF800, 'hE0}, '{3, 'hF800, 'hE0},
            '{2, 'hABCD, 'hAB}, '{0, 'h07E0, 'h1C}, '{0, 'h001F, 'h03}, '{1, 'h0000, 'h00},
            '{1, 'h07C0, 'h1F}, '{2, 'h1234, 'h12}};
    last_ovf = '{0, 0, 0};

    rst = 1'b1; vsync = 1'b0; href = 1'b0; data = 8'h00; enable = 1'b1; mode = 2'd0;
    tick(3);
    check_zero("reset");
    rst = 1'b0;
    tick(1);

    // Write latency and frame_done pulse timing on a single pixel.
    vsync = 1'b1; tick(2);
    vsync = 1'b0; tick(2);
    href = 1'b1; data = 8'hF8; tick(1);
    check("latency regW after high byte", int'(w1), 0);
    data = 8'h00; tick(1);
    check("latency regW after low byte", int'(w1), 1);
    check("latency addr", int'(a1), 0);
    check("latency data", int'(d1), 'hE0);
    href = 1'b0; tick(1);
    check("regW idle after write", int'(w1), 0);
    vsync = 1'b1; tick(1);
    check("frame_done pulse", int'(f1), 1);
    tick(1);
    check("frame_done one cycle", int'(f1), 0);

    for (int i = 0; i < 10; i++) begin
      fb.delete(); rl.delete();
      fb.push_back(tbl[i].pix >> 8);
      fb.push_back(tbl[i].pix & 'hFF);
      rl.push_back(2);
      send_frame(tbl[i].md, 1'b1, 1'b0, 1'b0);
      check_frame($sformatf("table%0d", i));
      w = (got_sz(1) > gs[1]) ? got_at(1, gs[1]) : mk_wr(-1, -1);
      check($sformatf("table%0d converted data", i), w.data, tbl[i].exp);
    end

    // Three rows of six pixels into a 4x2 window without decimation.
    fb.delete(); rl.delete();
    for (int r = 0; r < 3; r++) begin
      rl.push_back(12);
      for (int c = 0; c < 6; c++) begin
        fb.push_back(r * 16 + c);
        fb.push_back('h55);
      end
    end
    send_frame(2, 1'b1, 1'b0, 1'b0);
    check_frame("window");
    check("window writes", got_sz(1) - gs[1], 8);
    check("window overflow", int'(o1), 1);

    // Odd trailing byte discarded, next row restarts at the high byte.
    fb.delete(); rl.delete();
    rl.push_back(3);
    rl.push_back(4);
    for (int b = 0; b < 7; b++) fb.push_back(16 * b + 3);
    send_frame(2, 1'b1, 1'b0, 1'b0);
    check_frame("oddbyte");
    check("oddbyte writes", got_sz(1) - gs[1], 3);

    gen_frame(6, 4, 10);
    send_frame(0, 1'b0, 1'b0, 1'b0);
    check_frame("disabled");

    for (int i = 0; i < 6; i++) begin
      gen_frame(int'($urandom_range(30, 18)), 20, 44);
      send_frame(int'($urandom_range(0, 3)), 1'b1, 1'b0, ($urandom_range(0, 1) == 1));
      check_frame($sformatf("random%0d", i));
    end

    // Full-width rows at the default size, aborted by vsync in the middle of row 10.
    fb.delete(); rl.delete();
    for (int r = 0; r < 11; r++) begin
      rl.push_back((r == 10) ? 101 : 1280);
      for (int b = 0; b < rl[r]; b++) fb.push_back(int'($urandom_range(0, 255)));
    end
    send_frame(0, 1'b1, 1'b1, 1'b0);
    check_frame("abort");
    check("abort frame_done", done_of(0) - ds[0], 1);
    gen_frame(4, 8, 12);
    send_frame(1, 1'b1, 1'b0, 1'b0);
    check_frame("after_abort");
    w = (got_sz(0) > gs[0]) ? got_at(0, gs[0]) : mk_wr(-1, -1);
    check("after_abort first addr", w.addr, 0);

    // Reset in the middle of a row, then stray rows without a vsync edge.
    vsync = 1'b1; tick(3);
    vsync = 1'b0; enable = 1'b1; tick(2);
    href = 1'b1;
    for (int b = 0; b < 7; b++) begin
      data = 8'($urandom_range(0, 255));
      tick(1);
    end
    rst = 1'b1; tick(1);
    check_zero("midrow reset");
    rst = 1'b0;
    last_ovf = '{0, 0, 0};
    mark();
    for (int b = 0; b < 20; b++) begin
      data = 8'($urandom_range(0, 255));
      tick(1);
    end
    href = 1'b0; tick(2);
    href = 1'b1;
    for (int b = 0; b < 40; b++) begin
      data = 8'($urandom_range(0, 255));
      tick(1);
    end
    href = 1'b0; tick(2);
    for (int k = 0; k < 3; k++)
      check($sformatf("post-reset dut%0d writes", k), got_sz(k) - gs[k], 0);
    gen_frame(9, 10, 20);
    send_frame(0, 1'b1, 1'b0, 1'b0);
    check_frame("post_reset");

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
